parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
- Serial transmitter directly downstream of the 3-bit odd-parity generator stage.
- Accepts a parallel data word, computes its odd parity bit, and serialises one frame on a single line.
- Frame order: start bit, data LSB-first, parity bit, stop bit.
- Each bit is held for a programmable number of clock cycles, so the lab serial-link stage can consume it.

Parameters:
- DATA_WIDTH, 3, data bits per frame; legal range >= 1.
- BAUD_DIV, 4, clock cycles per transmitted bit; legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit data_in.
- ready  output  1  high when a load will be accepted this cycle.
- busy  output  1  high while a frame is on the line (START..STOP).
- tx  output  1  serial line; idle level 1.
- done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, tx=1, busy=0, ready=1, done=0, bit and baud counters 0, shift register 0.
- All outputs are registered or decoded from registered state; no combinational path from load/data_in to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: ready=1, tx=1. When load=1 at an edge:
  - capture data_in into the shift register;
  - capture parity = XNOR-reduction of data_in (odd parity: total ones incl. parity is odd);
  - go to START.
- START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
- DATA: tx = shift_reg[0] for BAUD_DIV cycles, then shift right and increment the index. After bit DATA_WIDTH-1 completes, go to PARITY.
- PARITY: tx = captured parity bit for BAUD_DIV cycles, then STOP.
- STOP: tx=1 for BAUD_DIV cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- Timing:
  - Load accepted at edge k: tx=0 visible from the cycle after edge k.
  - Frame length = (DATA_WIDTH+3)*BAUD_DIV cycles.
  - done rises (DATA_WIDTH+3)*BAUD_DIV cycles after acceptance.
- Baud counter: counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary. With BAUD_DIV=1 every bit lasts exactly one cycle.
- load while not IDLE: ignored entirely; no queuing, no corruption of the frame in flight.
- data_in changes mid-frame: no effect.
- Back-to-back: ready=1 and done=1 coincide in the first IDLE cycle. A load then is accepted and the next start bit follows on the next cycle, giving exactly one idle (tx=1) cycle between frames.
- rst mid-frame: at the next edge, state IDLE, tx=1, done=0 (no done pulse for the aborted frame), counters cleared, ready=1.
- rst and load in the same cycle: rst wins; load is dropped.
- busy = 1 exactly in START, DATA, PARITY, STOP; ready = ~busy.

Decomposition:
- Shared package parity_pkg holds:
  - state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit);
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - a clog2-style width helper for the counters.
- One natural sub-module: baud_tick_gen (BAUD_DIV counter with enable and synchronous clear, one-cycle tick output). The FSM uses the tick to advance bits.
- Parity is computed inline.

Test Plan:
- Reset: rst=1 for 2 cycles -> tx=1, busy=0, ready=1, done=0.
- Load 3'b000 (BAUD_DIV=4) -> tx 0,0,0,0,1,1, each held 4 cycles (parity=1), busy high 24 cycles, done pulse in cycle 25 after acceptance.
- Load 3'b101 -> tx 0,1,0,1,1,1 (parity=1). Load 3'b001 -> tx 0,1,0,0,0,1 (parity=0). Load 3'b111 -> parity bit 0.
- Load 3'b011, then load=1 with data_in=3'b111 at cycle 5 of the frame -> second load ignored; line carries 0,1,1,0,1,1 only.
- Back-to-back: load held high with 3'b110 presented on the done cycle -> exactly one tx=1 idle cycle, then the new frame 0,0,1,1,1,1.
- Assert rst at cycle 10 of a frame -> tx=1 and ready=1 next cycle, no done pulse. A subsequent load of 3'b010 produces the correct full frame 0,0,1,0,0,1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter: state encoding,
// line levels and the counter width helper.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Bits needed to count 0..n-1; never narrower than one bit so n=1 still works.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and emits a one-cycle
// tick on the last count of each bit period.
module baud_tick_gen
    import parity_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises one word per frame as start, data LSB-first, odd parity, stop,
// each bit held for BAUD_DIV clocks.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int BAUD_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx,
    output logic                  done
);

    localparam int IW = cnt_width(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IW-1:0]           bit_idx_q, bit_idx_d;
    logic                    parity_q, parity_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    baud_tick;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .srst (rst),
        .en   (state_q != IDLE),
        .clr  (state_q == IDLE),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d   = data_in;
                    parity_d  = ~^data_in;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is registered from the next state so tx changes on the same edge as the state.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign ready = ~busy;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench: a frame-level reference model is compared with the
// DUT every cycle, plus literal line patterns for hand-worked frames.
module tb_parity_frame_tx;

    localparam int DW = 3;
    localparam int BD = 4;
    localparam int NB = DW + 3;
    localparam int FL = NB * BD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready, busy, tx, done;

    int total = 0;
    int bad   = 0;

    // Reference model: frame position counted from acceptance.
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    int            m_t      = 0;
    logic [NB-1:0] m_bits   = '0;

    parity_frame_tx #(
        .DATA_WIDTH(DW),
        .BAUD_DIV  (BD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .load   (load),
        .ready  (ready),
        .busy   (busy),
        .tx     (tx),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic [DW-1:0] d);
        m_done = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t > FL) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_t      = 0;
            end
        end else if (l) begin
            m_active  = 1'b1;
            m_t       = 1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < DW; i++) m_bits[i+1] = d[i];
            m_bits[DW+1] = (($countones(d) % 2) == 0);
            m_bits[DW+2] = 1'b1;
        end
    endtask

    task automatic cycle();
        logic          r, l;
        logic [DW-1:0] d;
        logic          exp_tx;
        r = rst;
        l = load;
        d = data_in;
        @(posedge clk);
        model_step(r, l, d);
        #1;
        exp_tx = m_active ? m_bits[(m_t - 1) / BD] : 1'b1;
        check("tx",    32'(tx),    32'(exp_tx));
        check("busy",  32'(busy),  32'(m_active));
        check("ready", 32'(ready), 32'(!m_active));
        check("done",  32'(done),  32'(m_done));
    endtask

    // Sends one frame from idle; returns while sampling the done cycle.
    task automatic frame(input logic [DW-1:0] d, input logic [NB-1:0] exp_line,
                         input int inj, input string name);
        logic [NB-1:0] line;
        int            busy_n;
        line   = '0;
        busy_n = 0;
        load    = 1'b1;
        data_in = d;
        cycle();
        load    = 1'b0;
        data_in = DW'($urandom);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < BD; c++) begin
                if (c == 0) line[b] = tx;
                else if (tx !== line[b]) line[b] = 1'bx;
                busy_n += int'(busy);
                if (b * BD + c + 1 == inj) begin
                    load    = 1'b1;
                    data_in = '1;
                end else begin
                    load = 1'b0;
                end
                cycle();
            end
        end
        load = 1'b0;
        check({name, "_line"},  32'(line),   32'(exp_line));
        check({name, "_busyn"}, 32'(busy_n), 32'(FL));
        check({name, "_done"},  32'(done),   32'(1));
        check({name, "_idle"},  32'(tx),     32'(1));
        check({name, "_ready"}, 32'(ready),  32'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) cycle();
        check("rst_tx",    32'(tx),    32'(1));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done",  32'(done),  32'(0));
        rst = 1'b0;
        cycle();

        frame(3'b000, 6'b110000, 0, "f000");  cycle();
        frame(3'b101, 6'b111010, 0, "f101");  cycle();
        frame(3'b001, 6'b100010, 0, "f001");  cycle();
        frame(3'b111, 6'b101110, 0, "f111");  cycle();
        frame(3'b011, 6'b110110, 5, "ignore");
        frame(3'b110, 6'b111100, 0, "b2b");
        cycle();

        // Abort a frame mid-way with reset.
        load    = 1'b1;
        data_in = 3'b101;
        cycle();
        load = 1'b0;
        repeat (9) cycle();
        rst  = 1'b1;
        load = 1'b1;
        cycle();
        rst  = 1'b0;
        load = 1'b0;
        check("abort_tx",    32'(tx),    32'(1));
        check("abort_ready", 32'(ready), 32'(1));
        for (int i = 0; i < FL; i++) begin
            cycle();
            check("abort_nodone", 32'(done), 32'(0));
        end
        frame(3'b010, 6'b100100, 0, "after_rst");
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            load    = ($urandom_range(0, 3) == 0);
            data_in = DW'($urandom);
            cycle();
        end
        rst  = 1'b0;
        load = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
